// File: rtl/counter_mod_if.sv
// counter_mod_if: control/status bundle for one modulo-MOD counter stage.
//   reset_count : synchronous clear request
//   up          : increment enable for this cycle
//   max         : combinational wrap flag (up qualified), chains into next stage
//   out         : registered count value, $clog2(MOD) bits wide
// Modports: master drives reset_count/up and observes max/out; slave is the counter.
interface counter_mod_if #(
  parameter int MOD = 4
);
  localparam int WIDTH = $clog2(MOD);

  logic             reset_count;
  logic             up;
  logic             max;
  logic [WIDTH-1:0] out;

  modport master (
    output reset_count,
    output up,
    input  max,
    input  out
  );

  modport slave (
    input  reset_count,
    input  up,
    output max,
    output out
  );
endinterface

// File: rtl/counter_mod.sv
// counter_mod: modulo-MOD up-counter with synchronous clear and a combinational
// wrap flag. Stages chain by wiring one stage's max to the next stage's up.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, forces the count to 0
//   bus : counter_mod_if slave (reset_count, up in; max, out out)
module counter_mod #(
  parameter int MOD = 4
) (
  input  logic          clk,
  input  logic          rst,
  counter_mod_if.slave  bus
);
  localparam int               WIDTH = $clog2(MOD);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);

  // Out-of-range values (non-power-of-two MOD) keep incrementing and
  // recover only through natural overflow of the WIDTH-bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (bus.reset_count) begin
      count <= '0;
    end else if (bus.up) begin
      if (at_last) count <= '0;
      else         count <= count + WIDTH'(1);
    end
  end

  // max ignores reset_count so a clear at the wrap point still carries.
  assign bus.max = bus.up && at_last;
  assign bus.out = count;
endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod: cascaded pair B(MOD=4) -> A(MOD=5) plus an independent
// C(MOD=6) stage, checked against integer modulo models of the counting rules.
module tb_counter_mod;
  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  int ma = 0;
  int mb = 0;
  int mc = 0;

  counter_mod_if #(.MOD(5)) ifa ();
  counter_mod_if #(.MOD(4)) ifb ();
  counter_mod_if #(.MOD(6)) ifc ();

  counter_mod #(.MOD(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  counter_mod #(.MOD(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  counter_mod #(.MOD(6)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  assign ifa.up = ifb.max;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int v, input int modulus, input logic en, input logic clr);
    if (clr)     return 0;
    else if (en) return (v + 1) % modulus;
    else         return v;
  endfunction

  // Called just after a rising edge; drives inputs, checks combinational
  // flags mid-cycle, then checks the registered counts after the next edge.
  task automatic cycle(input logic upb, input logic rca, input logic rcb,
                       input logic upc, input logic rcc);
    logic emb, ema, emc;
    ifb.up          = upb;
    ifa.reset_count = rca;
    ifb.reset_count = rcb;
    ifc.up          = upc;
    ifc.reset_count = rcc;
    #1;
    emb = upb && (mb == 3);
    ema = emb && (ma == 4);
    emc = upc && (mc == 5);
    chk("max_b", 32'(ifb.max), 32'(emb));
    chk("max_a", 32'(ifa.max), 32'(ema));
    chk("max_c", 32'(ifc.max), 32'(emc));
    @(posedge clk);
    #1;
    ma = nxt(ma, 5, emb, rca);
    mb = nxt(mb, 4, upb, rcb);
    mc = nxt(mc, 6, upc, rcc);
    chk("out_a", 32'(ifa.out), ma);
    chk("out_b", 32'(ifb.out), mb);
    chk("out_c", 32'(ifc.out), mc);
  endtask

  initial begin
    rst             = 1'b0;
    ifb.up          = 1'b0;
    ifa.reset_count = 1'b0;
    ifb.reset_count = 1'b0;
    ifc.up          = 1'b0;
    ifc.reset_count = 1'b0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_out_a", 32'(ifa.out), 0);
      chk("rst_out_b", 32'(ifb.out), 0);
      chk("rst_max_b", 32'(ifb.max), 0);
    end
    rst = 1'b1;

    // Idle after release
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full cascade sweep: 20 cycles returns to (0,0)
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sweep_home_a", 32'(ifa.out), 0);
    chk("sweep_home_b", 32'(ifb.out), 0);

    // Pause: (0,1), hold, then 4 more -> (1,1)
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pause_a", 32'(ifa.out), 1);
    chk("pause_b", 32'(ifb.out), 1);

    // Sync clear beats up
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_a", 32'(ifa.out), 0);
    chk("clr_b", 32'(ifb.out), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_clr_b", 32'(ifb.out), 1);

    // Clear at wrap point on both stages: max_b still pulses, A stays 0
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrapclr_a", 32'(ifa.out), 0);
    // Clear only B at wrap point: the carry still advances A once
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrapclr_b_only_a", 32'(ifa.out), 1);
    chk("wrapclr_b_only_b", 32'(ifb.out), 0);

    // Async reset mid-count at out_b=2
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_async_b", 32'(ifb.out), 2);
    #2 rst = 1'b0;
    #1;
    chk("async_out_a", 32'(ifa.out), 0);
    chk("async_out_b", 32'(ifb.out), 0);
    chk("async_out_c", 32'(ifc.out), 0);
    chk("async_max_b", 32'(ifb.max), 0);
    ma = 0;
    mb = 0;
    mc = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume_b", 32'(ifb.out), 1);

    // Randomized traffic with gaps and occasional clears
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_mod.md
# counter_mod

Parameterised modulo-N up-counter with synchronous clear and a combinational wrap/carry flag. Counts 0..MOD-1 on enabled cycles and wraps to 0. The `max` output is qualified by `up`, so instances chain directly into multi-digit counters (e.g. nested loop indices in the LCMV datapath) by wiring one stage's `max` to the next stage's `up`.

## Interface

Parameters:
- `MOD`, default 4: modulus; count range 0..MOD-1. Legal range MOD ≥ 2.
- `WIDTH`, derived as `$clog2(MOD)` and not overridden: width of `out`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous active-low reset; `rst`=0 forces the count to 0 immediately.
- `reset_count`  input  1  synchronous clear of the count.
- `up`  input  1  increment enable for this cycle.
- `max`  output  1  combinational; high when `up`=1 and `out`==MOD-1, meaning the counter wraps on this edge.
- `out`  output  WIDTH  current count value, registered.

## Operation

- State is a single WIDTH-bit register `out`.
- Next-state priority, evaluated at each rising `clk` edge while `rst`=1:
  1. `reset_count`=1: `out` becomes 0. This takes priority over `up`.
  2. `up`=1 and `out`==MOD-1: `out` becomes 0 (wrap).
  3. `up`=1 otherwise: `out` becomes `out`+1.
  4. `up`=0: `out` holds.
- `max` = `up` AND (`out`==MOD-1). It is purely combinational with no register, and it does not depend on `reset_count`.
- Non-power-of-two MOD: values MOD..2^WIDTH-1 are never reached from reset. If such a value is present, `up` still increments it, and `max` stays low until the count wraps naturally through overflow. Reset is the only guaranteed recovery.
- Cascading: stage B (`up`=external enable) drives stage A (`up_a`=`max_b`). A advances exactly once per B wrap. With MOD_A=5 and MOD_B=4, the pair counts (a,b) in lexicographic order over 20 cycles.

## Timing

- `rst` asserted (0) asynchronously: `out`=0 and therefore `max`=0, independent of `clk`.
- `rst` deasserted: the first count update happens on the first rising edge after release.
- Latency: `out` updates one cycle after `up`/`reset_count` are sampled. `max` reflects the current `out` and `up` in the same cycle, with zero latency.
- Simultaneous `reset_count`=1 and `up`=1 at `out`==MOD-1: `out` goes to 0, and `max` is still 1 in that cycle.
- `up` held continuously: `out` follows the sequence 0,1,…,MOD-1,0,…, and `max` pulses for one cycle every MOD cycles.
- Gaps in `up` pause the count and do not affect the wrap phase.

## Test plan

- Reset and idle: hold `rst`=0 for 3 cycles, then release with `up`=0 for 2 cycles -> `out`=0 and `max`=0 throughout.
- Cascade full sweep: chain B (MOD=4) into A (MOD=5) via `up_a`=`max_b`, and hold `up_b`=1 for 20 cycles.
  - Required: (`out_a`,`out_b`) steps (0,0)…(4,3) in order.
  - Required: `max_b`=1 whenever `out_b`=3, and `max_a`=1 only at (4,3).
  - Required: the pair returns to (0,0) after 20 cycles.
- Pause: from (0,0), one `up_b` pulse gives (0,1). Then `up_b`=0 for 3 cycles keeps (0,1). Then `up_b`=1 for 4 cycles gives (1,1).
- Sync clear priority: from (1,1) with `up_b`=1, pulse `reset_count_a`=`reset_count_b`=1 for one cycle -> (0,0). Then `up_b`=1 for one cycle -> (0,1).
- Clear at wrap point: with `out`=MOD-1, `up`=1 and `reset_count`=1 -> `max`=1 in that cycle and `out`=0 next cycle, with no cascade double-count beyond the single `max` pulse.
- Async reset mid-count: drop `rst` between clock edges while `out`=2 -> `out`=0 before the next edge. After release, counting resumes from 0.
